// File: rtl/zero_skip_if.sv
// Interface bundle for zero_skip_encoder: dense input handshake, FIFO write side and frame status.
// The encoder uses the slave modport; the upstream/downstream environment uses master.
interface zero_skip_if #(
  parameter int D_WIDTH = 16,
  parameter int I_WIDTH = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [D_WIDTH-1:0] in_data;
  logic               fifo_full;
  logic               w_en;
  logic [D_WIDTH-1:0] data_out;
  logic [I_WIDTH-1:0] index_out;
  logic               frame_done;
  logic [I_WIDTH:0]   nz_count;

  modport master (
    output in_valid, in_data, fifo_full,
    input  in_ready, w_en, data_out, index_out, frame_done, nz_count
  );

  modport slave (
    input  in_valid, in_data, fifo_full,
    output in_ready, w_en, data_out, index_out, frame_done, nz_count
  );
endinterface

// File: rtl/zero_skip_encoder.sv
// Zero-skipping sparse encoder: drops zero activations of a 2**I_WIDTH frame and writes (value, index)
// pairs to a FIFO. Define ZERO_SKIP_THRESH_EN to prune elements with |value| <= THRESH as well.
module zero_skip_encoder #(
  parameter int          D_WIDTH = 16,
  parameter int          I_WIDTH = 4,
  parameter int unsigned THRESH  = 0
) (
  input logic        clk,
  input logic        rst,
  zero_skip_if.slave bus
);

  localparam logic [I_WIDTH-1:0] IDX_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e             state_q, state_d;
  logic [I_WIDTH-1:0] idx_q, idx_d;
  logic               out_valid_q, out_valid_d;
  logic [D_WIDTH-1:0] data_q, data_d;
  logic [I_WIDTH-1:0] index_q, index_d;
  logic [I_WIDTH:0]   emit_q, emit_d;
  logic [I_WIDTH:0]   nz_q, nz_d;
  logic               done_q, done_d;

  logic in_ready;
  logic w_en;
  logic xfer;
  logic is_nz;
  logic load;
  logic frame_end;

`ifdef ZERO_SKIP_THRESH_EN
  localparam logic [D_WIDTH:0] THRESH_W = (D_WIDTH+1)'(THRESH);

  // One extra bit so the most-negative input maps to magnitude 2**(D_WIDTH-1).
  logic [D_WIDTH:0] mag;

  always_comb begin
    if (bus.in_data[D_WIDTH-1]) begin
      mag = {1'b0, ~bus.in_data} + {{D_WIDTH{1'b0}}, 1'b1};
    end else begin
      mag = {1'b0, bus.in_data};
    end
  end

  assign is_nz = (mag > THRESH_W);
`else
  assign is_nz = (bus.in_data != '0);
`endif

  // State register and all datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      index_q     <= '0;
      emit_q      <= '0;
      nz_q        <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      index_q     <= index_d;
      emit_q      <= emit_d;
      nz_q        <= nz_d;
      done_q      <= done_d;
    end
  end

  // Output decode: the output register stalls on fifo_full, and DRAIN blocks the next frame.
  always_comb begin
    in_ready = (state_q != S_DRAIN) && (!out_valid_q || !bus.fifo_full);
    w_en     = out_valid_q && !bus.fifo_full;
  end

  assign xfer = bus.in_valid && in_ready;
  assign load = xfer && is_nz;

  always_comb begin
    idx_d       = xfer ? idx_q + 1'b1 : idx_q;
    out_valid_d = load || (out_valid_q && !w_en);
    data_d      = load ? bus.in_data : data_q;
    index_d     = load ? idx_q : index_q;
  end

  // Next-state logic; frame_end marks the edge that returns to IDLE.
  always_comb begin
    state_d   = state_q;
    frame_end = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (xfer) state_d = S_RUN;
      end
      S_RUN: begin
        if (xfer && (idx_q == IDX_LAST)) begin
          if (out_valid_d) begin
            state_d = S_DRAIN;
          end else begin
            state_d   = S_IDLE;
            frame_end = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (!out_valid_d) begin
          state_d   = S_IDLE;
          frame_end = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The write on the frame-closing edge still belongs to the closing frame.
  always_comb begin
    emit_d = frame_end ? '0 : emit_q + (I_WIDTH+1)'(w_en);
    nz_d   = frame_end ? emit_q + (I_WIDTH+1)'(w_en) : nz_q;
    done_d = frame_end;
  end

  assign bus.in_ready   = in_ready;
  assign bus.w_en       = w_en;
  assign bus.data_out   = data_q;
  assign bus.index_out  = index_q;
  assign bus.frame_done = done_q;
  assign bus.nz_count   = nz_q;

endmodule

// File: tb/tb_zero_skip_encoder.sv
// Directed, table-driven bench for zero_skip_encoder (16-bit data, 16-element frames, THRESH=2).
module tb_zero_skip_encoder;

  localparam int DW = 16;
  localparam int IW = 4;

  typedef struct {
    bit v;
    int d;
    bit ff;
    bit ew;
    bit cd;
    int ed;
    int ei;
    bit er;
    bit efd;
    int enz;
  } row_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  row_t rows[$];

  zero_skip_if #(.D_WIDTH(DW), .I_WIDTH(IW)) bus ();

  zero_skip_encoder #(.D_WIDTH(DW), .I_WIDTH(IW), .THRESH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void add(bit v, int d, bit ff, bit ew, bit cd, int ed, int ei,
                              bit er, bit efd, int enz);
    row_t r;
    r.v = v; r.d = d; r.ff = ff; r.ew = ew; r.cd = cd; r.ed = ed; r.ei = ei;
    r.er = er; r.efd = efd; r.enz = enz;
    rows.push_back(r);
  endfunction

  // Each row: inputs for one cycle and the outputs expected before that cycle's closing edge.
  task automatic apply_rows();
    foreach (rows[n]) begin
      @(posedge clk);
      #1;
      bus.in_valid  = rows[n].v;
      bus.in_data   = DW'(rows[n].d);
      bus.fifo_full = rows[n].ff;
      @(negedge clk);
      chk($sformatf("w_en[%0d]", n), int'(bus.w_en), int'(rows[n].ew));
      chk($sformatf("in_ready[%0d]", n), int'(bus.in_ready), int'(rows[n].er));
      chk($sformatf("frame_done[%0d]", n), int'(bus.frame_done), int'(rows[n].efd));
      chk($sformatf("nz_count[%0d]", n), int'(bus.nz_count), rows[n].enz);
      if (rows[n].cd) begin
        chk($sformatf("data_out[%0d]", n), int'($signed(bus.data_out)), rows[n].ed);
        chk($sformatf("index_out[%0d]", n), int'(bus.index_out), rows[n].ei);
      end
    end
    rows.delete();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_w_en", int'(bus.w_en), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_frame_done", int'(bus.frame_done), 0);
    chk("rst_nz_count", int'(bus.nz_count), 0);
    chk("rst_data_out", int'(bus.data_out), 0);
    @(negedge clk);
    rst = 1'b0;

    // Sparse frame 0,5,0,0,-3,0...
    add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 5, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 1, 1, 5, 1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, -3, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 1, 1, -3, 4, 1, 0, 0);
    for (int i = 6; i < 16; i++) add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, 2);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 2);

    // Dense frame 1..16 back-to-back; the last write happens in DRAIN.
    add(1, 1, 0, 0, 0, 0, 0, 1, 0, 2);
    for (int k = 1; k < 16; k++) add(1, k + 1, 0, 1, 1, k, k - 1, 1, 0, 2);
    add(0, 0, 0, 1, 1, 16, 15, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, 16);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 16);

    // Backpressure for 5 cycles on a pending entry, then last element stalled into DRAIN.
    add(1, 9, 0, 0, 0, 0, 0, 1, 0, 16);
    for (int i = 0; i < 5; i++) add(1, 0, 1, 0, 1, 9, 0, 0, 0, 16);
    add(1, 0, 0, 1, 1, 9, 0, 1, 0, 16);
    for (int i = 2; i < 15; i++) add(1, 0, 0, 0, 0, 0, 0, 1, 0, 16);
    add(1, 7, 0, 0, 0, 0, 0, 1, 0, 16);
    for (int i = 0; i < 3; i++) add(1, 3, 1, 0, 1, 7, 15, 0, 0, 16);
    add(1, 3, 0, 1, 1, 7, 15, 0, 0, 16);
    add(1, 3, 0, 0, 0, 0, 0, 1, 1, 2);
    add(0, 0, 0, 1, 1, 3, 0, 1, 0, 2);

    // Continue that frame up to idx 9 holding a pending nonzero entry.
    for (int i = 1; i < 9; i++) add(1, 0, 0, 0, 0, 0, 0, 1, 0, 2);
    add(1, 4, 0, 0, 0, 0, 0, 1, 0, 2);
    add(0, 0, 0, 1, 1, 4, 9, 1, 0, 2);
    apply_rows();

    // Asynchronous reset mid-cycle discards the pending entry.
    rst = 1'b1;
    #1;
    chk("midrst_w_en", int'(bus.w_en), 0);
    chk("midrst_in_ready", int'(bus.in_ready), 1);
    chk("midrst_nz_count", int'(bus.nz_count), 0);
    chk("midrst_index_out", int'(bus.index_out), 0);
    chk("midrst_data_out", int'(bus.data_out), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
`ifdef ZERO_SKIP_THRESH_EN
    add(1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, -2, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 3, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, -3, 0, 1, 1, 3, 2, 1, 0, 0);
    add(1, 0, 0, 1, 1, -3, 3, 1, 0, 0);
    for (int i = 5; i < 16; i++) add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, 2);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 2);
`else
    add(1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, -2, 0, 1, 1, 1, 0, 1, 0, 0);
    add(1, 3, 0, 1, 1, -2, 1, 1, 0, 0);
    add(1, -3, 0, 1, 1, 3, 2, 1, 0, 0);
    add(1, 0, 0, 1, 1, -3, 3, 1, 0, 0);
    for (int i = 5; i < 16; i++) add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, 4);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 4);
`endif

    // All-zero frame: pulse with count 0, never a write.
    for (int i = 0; i < 16; i++) add(1, 0, 0, 0, 0, 0, 0, 1, 0, (`ifdef ZERO_SKIP_THRESH_EN 2 `else 4 `endif));
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    apply_rows();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/zero_skip_encoder.md
ZERO_SKIP_ENCODER -- requirements
Module: zero_skip_encoder

Interface
REQ-001 Parameter D_WIDTH, default 16, data word width; matches FIFO D_WIDTH.
REQ-002 Parameter I_WIDTH, default 4, index width; frame length is 2**I_WIDTH elements.
REQ-003 Parameter THRESH, default 0, unsigned pruning magnitude; used only when the macro in REQ-027 is defined.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port in_valid  input  1  in_data holds a valid dense activation.
REQ-007 Port in_ready  output  1  block accepts in_data this cycle.
REQ-008 Port in_data  input  D_WIDTH  dense activation, two's complement.
REQ-009 Port fifo_full  input  1  downstream FIFO full flag.
REQ-010 Port w_en  output  1  write strobe to the downstream FIFO.
REQ-011 Port data_out  output  D_WIDTH  nonzero value to the FIFO data_in.
REQ-012 Port index_out  output  I_WIDTH  in-frame position of data_out, to the FIFO index_in.
REQ-013 Port frame_done  output  1  one-cycle pulse when a frame is fully emitted.
REQ-014 Port nz_count  output  I_WIDTH+1  number of entries emitted for the last completed frame.

Function
REQ-015 A transfer occurs on a rising edge where in_valid and in_ready are both 1; the element index is idx_cnt, an I_WIDTH-bit counter that increments per transfer and wraps from 2**I_WIDTH-1 to 0.
REQ-016 The output stage is one register (out_valid, data_out, index_out); a transferred element that is nonzero is loaded into it on the transfer edge, so latency is 1 cycle.
REQ-017 Zero elements are counted and indexed but not loaded; they never produce w_en.
REQ-018 w_en = out_valid AND NOT fifo_full (combinational); out_valid clears on an edge with w_en=1 unless a new nonzero element loads on the same edge.
REQ-019 in_ready = NOT out_valid OR NOT fifo_full; while out_valid=1 and fifo_full=1, data_out/index_out/w_en=0 hold and no input is accepted.
REQ-020 FSM states: IDLE (idx_cnt=0, no frame open), RUN (frame open), DRAIN (last element accepted, output register not yet empty).
REQ-021 IDLE->RUN on first transfer; RUN->DRAIN on transfer with idx_cnt=2**I_WIDTH-1 when the output register is nonempty after that edge; RUN->IDLE directly on that transfer otherwise; DRAIN->IDLE on the edge where out_valid clears.
REQ-022 in_ready is 0 in DRAIN; a new frame never starts before the previous frame's last entry is written.
REQ-023 frame_done pulses high for exactly one cycle, in the cycle after entering IDLE from RUN or DRAIN; nz_count updates on the same edge with the per-frame emission count (0..2**I_WIDTH), internal counter then clears.
REQ-024 A frame with all zeros produces no w_en, frame_done pulse, nz_count=0.

Reset
REQ-025 rst=1 asynchronously forces IDLE, idx_cnt=0, out_valid=0, w_en=0, data_out=0, index_out=0, frame_done=0, nz_count=0, internal count=0; a partly processed frame and pending output are discarded.
REQ-026 After rst deasserts, in_ready=1 and the next transfer is index 0 of a new frame.

Configuration
REQ-027 Macro ZERO_SKIP_THRESH_EN: when defined, an element is treated as zero if |in_data| <= THRESH (most-negative value treated as magnitude 2**(D_WIDTH-1)); when undefined, only in_data==0 is zero and THRESH is ignored.

Verification
REQ-028 Frame 0,5,0,0,-3,0..0 (16 elements), fifo_full=0 -> w_en twice: (5,idx1), (-3,idx4); frame_done once; nz_count=2.
REQ-029 Sixteen nonzero values 1..16 back-to-back -> 16 consecutive w_en, index_out 0..15, in_ready stays 1, nz_count=16.
REQ-030 Hold fifo_full=1 for 5 cycles while a nonzero entry is pending -> w_en=0, in_ready=0, data_out/index_out stable; entry written on first cycle fifo_full=0.
REQ-031 Last element (idx15)=7 with fifo_full=1 -> DRAIN, in_ready=0, frame_done delayed until write; next frame's first element gets index 0.
REQ-032 Assert rst mid-frame at idx 9 with pending output -> w_en drops immediately, no frame_done; new frame restarts at index 0.
REQ-033 With ZERO_SKIP_THRESH_EN, THRESH=2, input 1,-2,3,-3,0.. -> only (3,idx2),(-3,idx3) emitted; without macro, four entries emitted.
